// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: UART_TX defaults shared with the scheduler, plus scheduler state encoding
package uart_tx_pkg;
  localparam int DEF_WORD_SIZE    = 8;
  localparam int DEF_FRAME_CYCLES = 11;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    BRDY  = 3'd2,
    START = 3'd3,
    WAIT  = 3'd4
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after ptr, with wrap
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx
);
  logic [W-1:0] j;
  always_comb begin
    idx = '0;
    j = '0;
    // farthest offset first, so the nearest set request after ptr is written last
    for (int i = N; i >= 1; i--) begin
      j = W'((int'(ptr) + i) % N);
      if (req[j]) idx = j;
    end
    grant = |req ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one UART_TX among N_REQ byte producers
module uart_tx_scheduler
  import uart_tx_pkg::*;
#(
  parameter int WORD_SIZE    = DEF_WORD_SIZE,
  parameter int N_REQ        = 4,
  parameter int FRAME_CYCLES = DEF_FRAME_CYCLES
) (
  input  logic                          CLOCK,
  input  logic                          RESET,
  input  logic                          ENABLE,
  input  logic [N_REQ-1:0]              REQ_VALID,
  input  logic [N_REQ*WORD_SIZE-1:0]    REQ_DATA,
  output logic [N_REQ-1:0]              REQ_ACK,
  output logic [WORD_SIZE-1:0]          DATA_BUS,
  output logic                          LOAD_XMT_DATAREG,
  output logic                          BYTE_READY,
  output logic                          T_BYTE,
  output logic                          BUSY,
  output logic [$clog2(N_REQ)-1:0]      GRANT_ID,
  output logic                          TX_DONE
);
  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(FRAME_CYCLES + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [GW-1:0] ptr, win;
  logic [N_REQ-1:0] gnt;
  logic go;
  rr_arbiter #(.N(N_REQ)) u_arb (.req(REQ_VALID), .ptr(ptr), .grant(gnt), .idx(win));
  always_comb begin
    go = state == IDLE && ENABLE && |REQ_VALID;
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE:    state_n = go ? LOAD : IDLE;
      LOAD:    state_n = BRDY;
      BRDY:    state_n = START;
      START: begin
        state_n = WAIT;
        cnt_n = CW'(FRAME_CYCLES - 1);
      end
      WAIT: begin
        state_n = cnt == '0 ? IDLE : WAIT;
        cnt_n = cnt == '0 ? '0 : cnt - CW'(1);
      end
      default: state_n = IDLE;
    endcase
  end
  // each strobe is registered off the state it belongs to, so they come out one per cycle
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= GW'(N_REQ - 1);
      REQ_ACK <= '0;
      DATA_BUS <= '0;
      GRANT_ID <= '0;
      LOAD_XMT_DATAREG <= 1'b0;
      BYTE_READY <= 1'b0;
      T_BYTE <= 1'b0;
      BUSY <= 1'b0;
      TX_DONE <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      REQ_ACK <= go ? gnt : '0;
      if (go) begin
        ptr <= win;
        GRANT_ID <= win;
        DATA_BUS <= REQ_DATA[win*WORD_SIZE +: WORD_SIZE];
      end
      LOAD_XMT_DATAREG <= state == LOAD;
      BYTE_READY <= state == BRDY;
      T_BYTE <= state == START;
      BUSY <= state != IDLE || go;
      TX_DONE <= state == WAIT && cnt == '0;
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed scenarios plus randomized traffic against a frame-timing model
module tb_uart_tx_scheduler;
  localparam int N = 4, W = 8, F = 11;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [N-1:0] valid = '0;
  logic [N*W-1:0] data = '0;
  logic [N-1:0] ack;
  logic [W-1:0] dbus;
  logic load, brdy, tbyte, busy, done;
  logic [1:0] gid;
  logic [18:0] outs;
  int checks = 0, errors = 0;
  int cyc = 0, ack_cyc = -1000, m_ptr = N - 1, m_gid = 0;
  logic [W-1:0] m_data = '0;

  uart_tx_scheduler #(.WORD_SIZE(W), .N_REQ(N), .FRAME_CYCLES(F)) dut (
    .CLOCK(clk), .RESET(rst), .ENABLE(en), .REQ_VALID(valid), .REQ_DATA(data),
    .REQ_ACK(ack), .DATA_BUS(dbus), .LOAD_XMT_DATAREG(load), .BYTE_READY(brdy),
    .T_BYTE(tbyte), .BUSY(busy), .GRANT_ID(gid), .TX_DONE(done)
  );

  assign outs = {ack, dbus, load, brdy, tbyte, busy, gid, done};
  always #5 clk = ~clk;

  function automatic int pick(logic [N-1:0] v, int p);
    int w = (p + 1) % N;
    for (int s = 0; s < N && !v[w]; s++) w = (w + 1) % N;
    return w;
  endfunction

  // Model: a frame occupies cycles ack..ack+3+F; a new grant may be decided in its last cycle.
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    if (rst) begin
      ack_cyc <= -1000;
      m_ptr <= N - 1;
      m_gid <= 0;
      m_data <= '0;
    end else if (cyc - ack_cyc >= 3 + F && en && |valid) begin
      ack_cyc <= cyc + 1;
      m_ptr <= pick(valid, m_ptr);
      m_gid <= pick(valid, m_ptr);
      m_data <= data[pick(valid, m_ptr)*W +: W];
    end

  task automatic wait_ack(input int limit, output int n);
    n = 0;
    while (ack == '0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (ack == '0) n = -1;
  endtask

  task automatic wait_idle(input int limit, output int n);
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; valid = '0; data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", outs); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [5:0] exp;
    en = 1'b1; valid = 4'b0001; data = 32'h0000_00A5;
    @(negedge clk);
    checks++;
    if (ack !== 4'b0001 || dbus !== 8'hA5 || gid !== 2'd0)
      begin errors++; $display("FAIL single_ack: got ack=%b data=%h id=%0d expected 0001/a5/0", ack, dbus, gid); end
    valid = '0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      exp = {i == 1, i == 2, i == 3, i == 3 + F, i <= 3 + F, 1'b0};
      checks++;
      if ({load, brdy, tbyte, done, busy, |ack} !== exp || dbus !== 8'hA5)
        begin errors++; $display("FAIL single_t+%0d: got ld/br/tb/dn/busy/ack=%b data=%h expected %b/a5", i, {load, brdy, tbyte, done, busy, |ack}, dbus, exp); end
    end
  endtask

  task automatic test_round_robin();
    int n;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; valid = 4'hF; data = 32'h1312_1110;
    for (int g = 0; g < 5; g++) begin
      wait_ack(40, n);
      checks++;
      if (n < 0) begin errors++; $display("FAIL rr_timeout: grant %0d got none, expected an ack within 40 cycles", g); end
      else begin
        if (ack !== 4'(1 << (g % N)) || gid !== 2'(g % N) || dbus !== 8'(8'h10 + g % N))
          begin errors++; $display("FAIL rr_grant%0d: got ack=%b id=%0d data=%h expected id=%0d data=%h", g, ack, gid, dbus, g % N, 8'h10 + g % N); end
        if (g > 0) begin
          checks++;
          if (n + 1 != 4 + F) begin errors++; $display("FAIL rr_spacing%0d: got %0d cycles expected %0d", g, n + 1, 4 + F); end
        end
      end
      @(negedge clk);
    end
    valid = '0;
    wait_idle(40, n);
    checks++;
    if (n < 0) begin errors++; $display("FAIL rr_idle: got busy=%b expected 0 within 40 cycles", busy); end
  endtask

  task automatic test_late_request();
    int n;
    logic r3, r0;
    int seq[$];
    for (int trial = 0; trial < 3; trial++) begin
      r3 = 1'($urandom); r0 = 1'($urandom);
      valid = 4'b0100; data = $urandom;
      wait_ack(40, n);
      checks++;
      if (n < 0 || ack !== 4'b0100) begin errors++; $display("FAIL late_first: got ack=%b expected 0100", ack); end
      repeat (5) @(negedge clk);
      valid = {r3, 1'b1, 1'b1, r0};
      seq = {};
      if (r3) seq.push_back(3);
      if (r0) seq.push_back(0);
      seq.push_back(1);
      foreach (seq[j]) begin
        @(negedge clk);
        wait_ack(40, n);
        checks++;
        if (n < 0 || ack !== 4'(1 << seq[j]))
          begin errors++; $display("FAIL late_seq%0d_%0d: got ack=%b expected requester %0d", trial, j, ack, seq[j]); end
      end
      valid = '0;
      wait_idle(40, n);
      checks++;
      if (n < 0) begin errors++; $display("FAIL late_idle: got busy=%b expected 0", busy); end
    end
  endtask

  task automatic test_enable();
    int n, done_at, done_cnt, bad_ack;
    valid = 4'b0001; en = 1'b1; data = $urandom;
    wait_ack(40, n);
    checks++;
    if (n < 0 || ack !== 4'b0001) begin errors++; $display("FAIL en_first: got ack=%b expected 0001", ack); end
    repeat (5) @(negedge clk);
    en = 1'b0;
    done_at = -1; done_cnt = 0; bad_ack = 0;
    for (int i = 6; i <= 30; i++) begin
      @(negedge clk);
      if (done) begin done_at = i; done_cnt++; end
      if (ack != '0) bad_ack++;
    end
    checks++;
    if (done_at != 3 + F || done_cnt != 1)
      begin errors++; $display("FAIL en_done: got pulse at t+%0d count %0d expected t+%0d count 1", done_at, done_cnt, 3 + F); end
    checks++;
    if (bad_ack != 0) begin errors++; $display("FAIL en_blocked: got %0d ack cycles expected 0", bad_ack); end
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (ack !== 4'b0001) begin errors++; $display("FAIL en_resume: got ack=%b expected 0001", ack); end
    valid = '0;
    wait_idle(40, n);
    checks++;
    if (n < 0) begin errors++; $display("FAIL en_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    int n;
    valid = 4'b0010; data = $urandom;
    wait_ack(40, n);
    checks++;
    if (n < 0 || ack !== 4'b0010) begin errors++; $display("FAIL rmid_first: got ack=%b expected 0010", ack); end
    repeat (2) @(negedge clk);
    checks++;
    if (brdy !== 1'b1) begin errors++; $display("FAIL rmid_brdy: got %b expected 1", brdy); end
    rst = 1'b1; valid = 4'b0011;
    @(negedge clk);
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL rmid_cleared: got %h expected 0", outs); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ack !== 4'b0001 || gid !== 2'd0) begin errors++; $display("FAIL rmid_regrant: got ack=%b id=%0d expected 0001/0", ack, gid); end
    valid = '0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      checks++;
      if (tbyte !== (i == 3) || done !== (i == 3 + F))
        begin errors++; $display("FAIL rmid_t+%0d: got tbyte=%b done=%b expected %b/%b", i, tbyte, done, i == 3, i == 3 + F); end
    end
  endtask

  task automatic test_pulse();
    int n, bad;
    valid = 4'b0100; data = $urandom;
    wait_ack(40, n);
    checks++;
    if (n < 0 || ack !== 4'b0100) begin errors++; $display("FAIL pulse_first: got ack=%b expected 0100", ack); end
    valid = '0;
    repeat (6) @(negedge clk);
    valid = 4'b1000;
    @(negedge clk);
    valid = '0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ack != '0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL pulse_ack: got %0d ack cycles expected 0", bad); end
    checks++;
    if ({busy, load, brdy, tbyte, done} !== 5'b0) begin errors++; $display("FAIL pulse_idle: got %b expected 00000", {busy, load, brdy, tbyte, done}); end
  endtask

  task automatic test_random();
    logic [18:0] exp;
    int k;
    logic pl = 1'b0, pb = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      k = cyc - ack_cyc;
      exp = {(k == 0) ? 4'(1 << m_gid) : 4'b0, m_data, k == 1, k == 2, k == 3,
             k >= 0 && k <= 3 + F, 2'(m_gid), k == 3 + F};
      checks++;
      if (outs !== exp) begin errors++; $display("FAIL random_c%0d: got %h expected %h", c, outs, exp); end
      checks++;
      if ($countones({load, brdy, tbyte}) > 1 || (brdy && !pl) || (tbyte && !pb))
        begin errors++; $display("FAIL strobe_order_c%0d: got ld/br/tb=%b after %b/%b expected ordered one-hot", c, {load, brdy, tbyte}, pl, pb); end
      pl = load; pb = brdy;
      rst = $urandom_range(0, 199) == 0;
      en = $urandom_range(0, 7) != 0;
      valid = 4'($urandom) & 4'($urandom);
      data = $urandom;
    end
    rst = 1'b0; en = 1'b0; valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_late_request();
    test_enable();
    test_reset_mid();
    test_pulse();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
